// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit: forward-select
// encoding, memory-wait FSM states and the watchdog limit.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [7:0] WAIT_LIMIT = 8'd255;

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Operand forward selector: picks the youngest in-flight writer of rs_i,
// memory stage before writeback, never forwarding register x0.
module fwd_select
    import hazard_unit_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_e   fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/redirect control, memory-wait FSM
// with sticky watchdog. Define HAZARD_PERF_EN to add stall/flush cycle counters.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       RegWriteE,
    input  logic       ResultSrcE,
    input  logic       MemWriteE,
    input  logic       PCSrcE,
    input  logic       MemReadyM,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    logic [4:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
    logic       reg_write_m_q, reg_write_m_d;
    logic       result_src_m_q, result_src_m_d;
    logic       mem_write_m_q, mem_write_m_d;
    logic       reg_write_w_q, reg_write_w_d;
    hz_state_e  state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       mem_access_m, mem_stall, load_use;
    fwd_sel_e   fwd_a, fwd_b;

    assign mem_access_m = result_src_m_q | mem_write_m_q;

    // The cycle MemReadyM rises the access completes, so the pipeline advances then.
    assign mem_stall = ((state_q == MEM_WAIT) || mem_access_m) && !MemReadyM;
    assign load_use  = ResultSrcE && RegWriteE && (RdE != 5'd0)
                       && ((RdE == Rs1D) || (RdE == Rs2D));

    fwd_select u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (rd_m_q),
        .reg_write_m_i (reg_write_m_q),
        .rd_w_i        (rd_w_q),
        .reg_write_w_i (reg_write_w_q),
        .fwd_o         (fwd_a)
    );

    fwd_select u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (rd_m_q),
        .reg_write_m_i (reg_write_m_q),
        .rd_w_i        (rd_w_q),
        .reg_write_w_i (reg_write_w_q),
        .fwd_o         (fwd_b)
    );

    always_comb begin
        rd_m_d         = rd_m_q;
        reg_write_m_d  = reg_write_m_q;
        result_src_m_d = result_src_m_q;
        mem_write_m_d  = mem_write_m_q;
        rd_w_d         = rd_m_q;
        reg_write_w_d  = 1'b0;
        if (!mem_stall) begin
            rd_m_d         = RdE;
            reg_write_m_d  = RegWriteE;
            result_src_m_d = ResultSrcE;
            mem_write_m_d  = MemWriteE;
            reg_write_w_d  = reg_write_m_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_access_m && !MemReadyM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q != WAIT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
                if (MemReadyM) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        timeout_d = timeout_q || (wait_cnt_d == WAIT_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_m_q         <= 5'd0;
            reg_write_m_q  <= 1'b0;
            result_src_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            rd_w_q         <= 5'd0;
            reg_write_w_q  <= 1'b0;
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            timeout_q      <= 1'b0;
        end else begin
            rd_m_q         <= rd_m_d;
            reg_write_m_q  <= reg_write_m_d;
            result_src_m_q <= result_src_m_d;
            mem_write_m_q  <= mem_write_m_d;
            rd_w_q         <= rd_w_d;
            reg_write_w_q  <= reg_write_w_d;
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    // A held redirect during a memory stall needs no pending flag: E is frozen,
    // so PCSrcE is still asserted on the first cycle the stall releases.
    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        MemTimeout = 1'b0;
        if (!rst) begin
            ForwardA_E = fwd_a;
            ForwardB_E = fwd_b;
            MemTimeout = timeout_d;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            if (StallF) stall_count_q <= stall_count_q + 32'd1;
            if (FlushE) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule
